// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor-side bus of the branch resolve unit.
// The master drives fetch and execute requests; the slave (the unit) returns
// queue status, the flush/redirect pulse, predictor training and statistics.
interface branch_resolve_unit_if #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    logic             F_PUSH;
    logic [IDX_W-1:0] F_INDEX;
    logic [31:0]      F_PC;
    logic             F_PRED;
    logic             EX_VALID;
    logic             EX_TAKEN;
    logic [31:0]      EX_TARGET;
    logic             FULL;
    logic             EMPTY;
    logic             MISPREDICT;
    logic [31:0]      REDIRECT_PC;
    logic             UPD_ENABLE;
    logic [IDX_W-1:0] UPD_INDEX;
    logic             UPD_OUTCOME;
    logic [CNT_W-1:0] BR_COUNT;
    logic [CNT_W-1:0] MISS_COUNT;

    modport master (
        output F_PUSH, F_INDEX, F_PC, F_PRED, EX_VALID, EX_TAKEN, EX_TARGET,
        input  FULL, EMPTY, MISPREDICT, REDIRECT_PC, UPD_ENABLE, UPD_INDEX,
               UPD_OUTCOME, BR_COUNT, MISS_COUNT
    );

    modport slave (
        input  F_PUSH, F_INDEX, F_PC, F_PRED, EX_VALID, EX_TAKEN, EX_TARGET,
        output FULL, EMPTY, MISPREDICT, REDIRECT_PC, UPD_ENABLE, UPD_INDEX,
               UPD_OUTCOME, BR_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of in-flight predicted branches. Resolving the head entry
// trains the 2-bit predictor, flags mispredictions, flushes younger
// (wrong-path) entries and supplies the corrected fetch PC.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  CLOCK,
    input  logic                  INIT,
    branch_resolve_unit_if.slave  bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Branch queue storage
    logic [IDX_W-1:0] idx_mem_q  [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];
    logic             pred_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic             upd_enable_q,  upd_enable_d;
    logic [IDX_W-1:0] upd_index_q,   upd_index_d;
    logic             upd_outcome_q, upd_outcome_d;
    logic             mispredict_q,  mispredict_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_count_q,    br_count_d;
    logic [CNT_W-1:0] miss_count_q,  miss_count_d;

    logic full, empty, resolve, miss, push_ok;

    // Queue status, resolve/mispredict detection and next-state computation
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        full          = (count_q == FULL_CNT);
        empty         = (count_q == '0);
        resolve       = bus.EX_VALID && !empty;
        miss          = resolve && (pred_mem_q[rd_ptr_q] != bus.EX_TAKEN);
        // A full queue can still accept a push when the head leaves this cycle,
        // unless that head mispredicted (the push is then wrong-path).
        push_ok       = bus.F_PUSH && !miss && (!full || resolve);

        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        upd_enable_d  = resolve;
        upd_index_d   = upd_index_q;
        upd_outcome_d = upd_outcome_q;
        mispredict_d  = miss;
        redirect_pc_d = redirect_pc_q;
        br_count_d    = br_count_q;
        miss_count_d  = miss_count_q;

        if (miss) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (resolve) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (push_ok && !resolve)      count_d = count_q + (PTR_W + 1)'(1);
            else if (!push_ok && resolve) count_d = count_q - (PTR_W + 1)'(1);
        end

        if (resolve) begin
            upd_index_d   = idx_mem_q[rd_ptr_q];
            upd_outcome_d = bus.EX_TAKEN;
            if (br_count_q != CNT_MAX) br_count_d = br_count_q + CNT_W'(1);
        end

        if (miss) begin
            redirect_pc_d = bus.EX_TAKEN ? bus.EX_TARGET : pc_mem_q[rd_ptr_q] + 32'd4;
            if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    // Write accepted fetch branches into the queue storage
    always_ff @(posedge CLOCK) begin
        // NOTE: storage is not reset; an entry is only read after a push has written it.
        if (!INIT && push_ok) begin
            idx_mem_q[wr_ptr_q]  <= bus.F_INDEX;
            pc_mem_q[wr_ptr_q]   <= bus.F_PC;
            pred_mem_q[wr_ptr_q] <= bus.F_PRED;
        end
    end

    // Control state and registered outputs, synchronous reset has priority
    always_ff @(posedge CLOCK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (INIT) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            upd_enable_q  <= 1'b0;
            upd_index_q   <= '0;
            upd_outcome_q <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            br_count_q    <= '0;
            miss_count_q  <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            upd_enable_q  <= upd_enable_d;
            upd_index_q   <= upd_index_d;
            upd_outcome_q <= upd_outcome_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            br_count_q    <= br_count_d;
            miss_count_q  <= miss_count_d;
        end
    end

    assign bus.FULL        = full;
    assign bus.EMPTY       = empty;
    assign bus.MISPREDICT  = mispredict_q;
    assign bus.REDIRECT_PC = redirect_pc_q;
    assign bus.UPD_ENABLE  = upd_enable_q;
    assign bus.UPD_INDEX   = upd_index_q;
    assign bus.UPD_OUTCOME = upd_outcome_q;
    assign bus.BR_COUNT    = br_count_q;
    assign bus.MISS_COUNT  = miss_count_q;
endmodule
